stage4_mem: RTL and testbench

STAGE4_MEM -- requirements
Module: stage4_mem

---
 rtl/stage4_mem.sv | 253 +++++++++++++++++++++++++
 tb/tb_stage4_mem.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage4_mem.sv
// stage4_mem: MEM pipeline stage with a stalling data-memory handshake, timeout and MEM/WB register.
// Defining STAGE4_MEM_SUBWORD_EN adds byte/half accesses via mem_size and mem_sign.
module stage4_mem #(
  parameter int unsigned DM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        regwrite,
  input  logic        memtoreg,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] alurslt,
  input  logic [31:0] data2,
  input  logic [4:0]  wrreg,
`ifdef STAGE4_MEM_SUBWORD_EN
  input  logic [1:0]  mem_size,
  input  logic        mem_sign,
`endif
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_be,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        wb_valid,
  output logic        regwrite_out,
  output logic        memtoreg_out,
  output logic [31:0] rdata_out,
  output logic [31:0] alurslt_out,
  output logic [4:0]  wrreg_out,
  output logic        stall,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam logic [7:0] TIMEOUT_LIM = 8'(DM_TIMEOUT);
  localparam logic [1:0] SZ_BYTE     = 2'b00;
  localparam logic [1:0] SZ_HALF     = 2'b01;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        lat_we_q, lat_we_d;
  logic [31:0] lat_addr_q, lat_addr_d;
  logic [31:0] lat_wdata_q, lat_wdata_d;
  logic [3:0]  lat_be_q, lat_be_d;
  logic        lat_regwrite_q, lat_regwrite_d;
  logic        lat_memtoreg_q, lat_memtoreg_d;
  logic [4:0]  lat_wrreg_q, lat_wrreg_d;
  logic [1:0]  lat_size_q, lat_size_d;
  logic        lat_sign_q, lat_sign_d;

  logic        wb_valid_q, wb_valid_d;
  logic        regwrite_out_q, regwrite_out_d;
  logic        memtoreg_out_q, memtoreg_out_d;
  logic [31:0] rdata_out_q, rdata_out_d;
  logic [31:0] alurslt_out_q, alurslt_out_d;
  logic [4:0]  wrreg_out_q, wrreg_out_d;
  logic        misalign_q, misalign_d;
  logic        bus_err_q, bus_err_d;

  logic [1:0]  size_c;
  logic        sign_c;
  logic        aligned_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [15:0] lane_c;
  logic [31:0] rdata_ext_c;
  logic        req_c, stall_c;

`ifdef STAGE4_MEM_SUBWORD_EN
  assign size_c = mem_size;
  assign sign_c = mem_sign;
`else
  assign size_c = 2'b10;
  assign sign_c = 1'b0;
`endif

  // Lane enables, store replication and alignment for the incoming EX/MEM op
  always_comb begin
    aligned_c = (alurslt[1:0] == 2'b00);
    be_c      = 4'hF;
    wdata_c   = data2;
    case (size_c)
      SZ_BYTE: begin
        aligned_c = 1'b1;
        be_c      = 4'b0001 << alurslt[1:0];
        wdata_c   = {4{data2[7:0]}};
      end
      SZ_HALF: begin
        aligned_c = ~alurslt[0];
        be_c      = alurslt[1] ? 4'b1100 : 4'b0011;
        wdata_c   = {2{data2[15:0]}};
      end
      default: ;
    endcase
  end

  // Load extraction uses the latched address/size since the op has left EX/MEM
  always_comb begin
    lane_c      = 16'(dm_rdata >> {lat_addr_q[1:0], 3'b000});
    rdata_ext_c = dm_rdata;
    case (lat_size_q)
      SZ_BYTE: rdata_ext_c = {{24{lat_sign_q & lane_c[7]}}, lane_c[7:0]};
      SZ_HALF: rdata_ext_c = {{16{lat_sign_q & lane_c[15]}}, lane_c[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    lat_we_d       = lat_we_q;
    lat_addr_d     = lat_addr_q;
    lat_wdata_d    = lat_wdata_q;
    lat_be_d       = lat_be_q;
    lat_regwrite_d = lat_regwrite_q;
    lat_memtoreg_d = lat_memtoreg_q;
    lat_wrreg_d    = lat_wrreg_q;
    lat_size_d     = lat_size_q;
    lat_sign_d     = lat_sign_q;
    wb_valid_d     = 1'b0;
    regwrite_out_d = 1'b0;
    memtoreg_out_d = 1'b0;
    rdata_out_d    = '0;
    alurslt_out_d  = '0;
    wrreg_out_d    = '0;
    misalign_d     = 1'b0;
    bus_err_d      = bus_err_q;
    req_c          = 1'b0;
    stall_c        = 1'b0;
    dm_we          = memwrite;
    dm_addr        = alurslt;
    dm_wdata       = wdata_c;
    dm_be          = be_c;

    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (!(memread || memwrite)) begin
            wb_valid_d     = 1'b1;
            regwrite_out_d = regwrite;
            memtoreg_out_d = memtoreg;
            alurslt_out_d  = alurslt;
            wrreg_out_d    = wrreg;
          end else if (aligned_c) begin
            req_c          = 1'b1;
            stall_c        = 1'b1;
            state_d        = WAIT;
            cnt_d          = '0;
            lat_we_d       = memwrite;
            lat_addr_d     = alurslt;
            lat_wdata_d    = wdata_c;
            lat_be_d       = be_c;
            lat_regwrite_d = regwrite & ~memwrite;
            lat_memtoreg_d = memtoreg;
            lat_wrreg_d    = wrreg;
            lat_size_d     = size_c;
            lat_sign_d     = sign_c;
          end else begin
            misalign_d = 1'b1;
          end
        end
      end
      WAIT: begin
        req_c    = 1'b1;
        dm_we    = lat_we_q;
        dm_addr  = lat_addr_q;
        dm_wdata = lat_wdata_q;
        dm_be    = lat_be_q;
        if (dm_ack) begin
          state_d        = IDLE;
          wb_valid_d     = 1'b1;
          regwrite_out_d = lat_regwrite_q;
          memtoreg_out_d = lat_memtoreg_q;
          rdata_out_d    = rdata_ext_c;
          alurslt_out_d  = lat_addr_q;
          wrreg_out_d    = lat_wrreg_q;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + 8'd1;
          // Counter reaches the limit on this edge: abandon; ack above takes priority
          if (cnt_q + 8'd1 == TIMEOUT_LIM) begin
            state_d   = IDLE;
            bus_err_d = 1'b1;
          end
        end
      end
    endcase
  end

  // Reset must silence the handshake immediately, not only at the next edge
  assign dm_req = req_c & rst_n;
  assign stall  = stall_c & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      lat_we_q       <= 1'b0;
      lat_addr_q     <= '0;
      lat_wdata_q    <= '0;
      lat_be_q       <= '0;
      lat_regwrite_q <= 1'b0;
      lat_memtoreg_q <= 1'b0;
      lat_wrreg_q    <= '0;
      lat_size_q     <= '0;
      lat_sign_q     <= 1'b0;
      wb_valid_q     <= 1'b0;
      regwrite_out_q <= 1'b0;
      memtoreg_out_q <= 1'b0;
      rdata_out_q    <= '0;
      alurslt_out_q  <= '0;
      wrreg_out_q    <= '0;
      misalign_q     <= 1'b0;
      bus_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      lat_we_q       <= lat_we_d;
      lat_addr_q     <= lat_addr_d;
      lat_wdata_q    <= lat_wdata_d;
      lat_be_q       <= lat_be_d;
      lat_regwrite_q <= lat_regwrite_d;
      lat_memtoreg_q <= lat_memtoreg_d;
      lat_wrreg_q    <= lat_wrreg_d;
      lat_size_q     <= lat_size_d;
      lat_sign_q     <= lat_sign_d;
      wb_valid_q     <= wb_valid_d;
      regwrite_out_q <= regwrite_out_d;
      memtoreg_out_q <= memtoreg_out_d;
      rdata_out_q    <= rdata_out_d;
      alurslt_out_q  <= alurslt_out_d;
      wrreg_out_q    <= wrreg_out_d;
      misalign_q     <= misalign_d;
      bus_err_q      <= bus_err_d;
    end
  end

  assign wb_valid     = wb_valid_q;
  assign regwrite_out = regwrite_out_q;
  assign memtoreg_out = memtoreg_out_q;
  assign rdata_out    = rdata_out_q;
  assign alurslt_out  = alurslt_out_q;
  assign wrreg_out    = wrreg_out_q;
  assign misalign_err = misalign_q;
  assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_stage4_mem.sv
// Self-checking bench for stage4_mem: transaction-level reference model with randomized ops.
// Built with STAGE4_MEM_SUBWORD_EN it also exercises byte/half accesses.
module tb_stage4_mem;

  localparam int unsigned TMO = 4;

  logic        clk, rst_n;
  logic        ex_valid, regwrite, memtoreg, memread, memwrite;
  logic [31:0] alurslt, data2;
  logic [4:0]  wrreg;
`ifdef STAGE4_MEM_SUBWORD_EN
  logic [1:0]  mem_size;
  logic        mem_sign;
`endif
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        wb_valid, regwrite_out, memtoreg_out;
  logic [31:0] rdata_out, alurslt_out;
  logic [4:0]  wrreg_out;
  logic        stall, misalign_err, bus_err;

  int   checks = 0;
  int   errors = 0;
  logic exp_bus_err = 1'b0;

  stage4_mem #(.DM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .regwrite(regwrite),
    .memtoreg(memtoreg), .memread(memread), .memwrite(memwrite),
    .alurslt(alurslt), .data2(data2), .wrreg(wrreg),
`ifdef STAGE4_MEM_SUBWORD_EN
    .mem_size(mem_size), .mem_sign(mem_sign),
`endif
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .wb_valid(wb_valid), .regwrite_out(regwrite_out), .memtoreg_out(memtoreg_out),
    .rdata_out(rdata_out), .alurslt_out(alurslt_out), .wrreg_out(wrreg_out),
    .stall(stall), .misalign_err(misalign_err), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---- reference model: access width in bytes drives every rule ----
  function automatic int m_lanes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic m_aligned(input logic [31:0] a, input logic [1:0] sz);
    return (int'(a[1:0]) % m_lanes(sz)) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [31:0] a, input logic [1:0] sz);
    int n;
    n = m_lanes(sz);
    if (n == 4) return 4'hF;
    return 4'(((1 << n) - 1) << int'(a[1:0]));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] d, input logic [1:0] sz);
    logic [31:0] r;
    int n;
    n = m_lanes(sz);
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = d[(i % n)*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] r, input logic [31:0] a,
                                         input logic [1:0] sz, input logic sg);
    logic [31:0] v, mask;
    int bits;
    bits = m_lanes(sz) * 8;
    if (bits == 32) return r;
    v    = r >> (int'(a[1:0]) * 8);
    mask = (32'h1 << bits) - 32'h1;
    v    = v & mask;
    if (sg && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives one EX/MEM op in the current cycle and follows it to completion.
  // ack_lat: WAIT cycle (1-based) in which dm_ack is given; 0 means never.
  task automatic run_op(input logic rd, input logic wr, input logic rw, input logic mt,
                        input logic [31:0] addr, input logic [31:0] d2, input logic [4:0] wr_r,
                        input logic [1:0] sz, input logic sg, input int ack_lat,
                        input logic [31:0] ack_data, input string tag);
    logic        memop, al, ack, exp_req;
    logic [31:0] exp_wd, ack_rdata;
    logic [3:0]  exp_be;
    memop   = rd | wr;
    al      = m_aligned(addr, sz);
    exp_req = memop & al;
    exp_wd  = m_wdata(d2, sz);
    exp_be  = m_be(addr, sz);

    ex_valid = 1'b1; memread = rd; memwrite = wr; regwrite = rw; memtoreg = mt;
    alurslt = addr; data2 = d2; wrreg = wr_r;
`ifdef STAGE4_MEM_SUBWORD_EN
    mem_size = sz; mem_sign = sg;
`endif
    dm_ack = 1'($urandom_range(0, 1));
    dm_rdata = $urandom;
    #1;
    checks++; if (dm_req !== exp_req) begin errors++; $display("FAIL %s issue_req got=%0b exp=%0b", tag, dm_req, exp_req); end
    checks++; if (stall !== exp_req) begin errors++; $display("FAIL %s issue_stall got=%0b exp=%0b", tag, stall, exp_req); end
    if (exp_req) begin
      checks++; if (dm_addr !== addr) begin errors++; $display("FAIL %s issue_addr got=%h exp=%h", tag, dm_addr, addr); end
      checks++; if (dm_we !== wr) begin errors++; $display("FAIL %s issue_we got=%0b exp=%0b", tag, dm_we, wr); end
      checks++; if (dm_be !== exp_be) begin errors++; $display("FAIL %s issue_be got=%b exp=%b", tag, dm_be, exp_be); end
      if (wr) begin
        checks++; if (dm_wdata !== exp_wd) begin errors++; $display("FAIL %s issue_wdata got=%h exp=%h", tag, dm_wdata, exp_wd); end
      end
    end
    tick();

    ex_valid = 1'b0; memread = 1'($urandom); memwrite = 1'($urandom); regwrite = 1'($urandom);
    memtoreg = 1'($urandom); alurslt = $urandom; data2 = $urandom; wrreg = 5'($urandom);
`ifdef STAGE4_MEM_SUBWORD_EN
    mem_size = 2'($urandom); mem_sign = 1'($urandom);
`endif
    dm_ack = 1'b0;
    checks++; if (bus_err !== exp_bus_err) begin errors++; $display("FAIL %s bus_err got=%0b exp=%0b", tag, bus_err, exp_bus_err); end

    if (!memop) begin
      checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL %s alu_valid got=%0b exp=1", tag, wb_valid); end
      checks++; if (regwrite_out !== rw) begin errors++; $display("FAIL %s alu_regwrite got=%0b exp=%0b", tag, regwrite_out, rw); end
      checks++; if (memtoreg_out !== mt) begin errors++; $display("FAIL %s alu_memtoreg got=%0b exp=%0b", tag, memtoreg_out, mt); end
      checks++; if (alurslt_out !== addr) begin errors++; $display("FAIL %s alu_rslt got=%h exp=%h", tag, alurslt_out, addr); end
      checks++; if (wrreg_out !== wr_r) begin errors++; $display("FAIL %s alu_wrreg got=%0d exp=%0d", tag, wrreg_out, wr_r); end
      return;
    end

    if (!al) begin
      checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL %s misalign_pulse got=%0b exp=1", tag, misalign_err); end
      checks++; if (wb_valid !== 1'b0 || regwrite_out !== 1'b0) begin errors++; $display("FAIL %s misalign_bubble got=%0b/%0b exp=0/0", tag, wb_valid, regwrite_out); end
      tick();
      checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL %s misalign_clear got=%0b exp=0", tag, misalign_err); end
      return;
    end

    checks++; if (wb_valid !== 1'b0 || regwrite_out !== 1'b0) begin errors++; $display("FAIL %s issue_bubble got=%0b/%0b exp=0/0", tag, wb_valid, regwrite_out); end
    for (int k = 1; k <= int'(TMO); k++) begin
      ack = (k == ack_lat);
      ack_rdata = ack ? ack_data : $urandom;
      dm_ack = ack;
      dm_rdata = ack_rdata;
      #1;
      checks++; if (dm_req !== 1'b1) begin errors++; $display("FAIL %s wait_req c%0d got=%0b exp=1", tag, k, dm_req); end
      checks++; if (stall !== !ack) begin errors++; $display("FAIL %s wait_stall c%0d got=%0b exp=%0b", tag, k, stall, !ack); end
      checks++; if (dm_addr !== addr || dm_we !== wr || dm_be !== exp_be) begin errors++; $display("FAIL %s wait_hold c%0d got=%h/%0b/%b exp=%h/%0b/%b", tag, k, dm_addr, dm_we, dm_be, addr, wr, exp_be); end
      if (wr) begin
        checks++; if (dm_wdata !== exp_wd) begin errors++; $display("FAIL %s wait_wdata c%0d got=%h exp=%h", tag, k, dm_wdata, exp_wd); end
      end
      tick();
      dm_ack = 1'b0;
      if (ack) begin
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL %s ack_valid got=%0b exp=1", tag, wb_valid); end
        checks++; if (regwrite_out !== (rw & !wr)) begin errors++; $display("FAIL %s ack_regwrite got=%0b exp=%0b", tag, regwrite_out, rw & !wr); end
        checks++; if (memtoreg_out !== mt) begin errors++; $display("FAIL %s ack_memtoreg got=%0b exp=%0b", tag, memtoreg_out, mt); end
        checks++; if (alurslt_out !== addr || wrreg_out !== wr_r) begin errors++; $display("FAIL %s ack_fields got=%h/%0d exp=%h/%0d", tag, alurslt_out, wrreg_out, addr, wr_r); end
        if (rd && !wr) begin
          checks++; if (rdata_out !== m_load(ack_data, addr, sz, sg)) begin errors++; $display("FAIL %s ack_rdata got=%h exp=%h", tag, rdata_out, m_load(ack_data, addr, sz, sg)); end
        end
        checks++; if (bus_err !== exp_bus_err) begin errors++; $display("FAIL %s ack_bus_err got=%0b exp=%0b", tag, bus_err, exp_bus_err); end
        return;
      end
      checks++; if (wb_valid !== 1'b0 || regwrite_out !== 1'b0) begin errors++; $display("FAIL %s wait_bubble c%0d got=%0b/%0b exp=0/0", tag, k, wb_valid, regwrite_out); end
      if (k == int'(TMO)) begin
        exp_bus_err = 1'b1;
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL %s timeout_bus_err got=%0b exp=1", tag, bus_err); end
        checks++; if (dm_req !== 1'b0) begin errors++; $display("FAIL %s timeout_req got=%0b exp=0", tag, dm_req); end
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    ex_valid = 1'b1; memread = 1'b1; memwrite = 1'b0; regwrite = 1'b1; memtoreg = 1'b1;
    alurslt = 32'h40; data2 = '0; wrreg = 5'd1; dm_ack = 1'b1; dm_rdata = $urandom;
`ifdef STAGE4_MEM_SUBWORD_EN
    mem_size = 2'b10; mem_sign = 1'b0;
`endif
    #2;
    checks++; if (dm_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL reset_handshake got=%0b/%0b exp=0/0", dm_req, stall); end
    tick();
    checks++; if ({wb_valid, regwrite_out, memtoreg_out, rdata_out, alurslt_out, wrreg_out} !== '0) begin errors++; $display("FAIL reset_memwb got=%0b%0b%0b %h %h %0d exp=all zero", wb_valid, regwrite_out, memtoreg_out, rdata_out, alurslt_out, wrreg_out); end
    checks++; if (misalign_err !== 1'b0 || bus_err !== 1'b0) begin errors++; $display("FAIL reset_status got=%0b/%0b exp=0/0", misalign_err, bus_err); end
    ex_valid = 1'b0; dm_ack = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL idle_bubble got=%0b exp=0", wb_valid); end
  endtask

  task automatic test_alu;
    run_op(1'b0, 1'b0, 1'b1, 1'b0, 32'h5, 32'h0, 5'd3, 2'b10, 1'b0, 0, 32'h0, "alu_directed");
    for (int i = 0; i < 6; i++)
      run_op(1'b0, 1'b0, 1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom),
             2'b10, 1'b0, 0, 32'h0, "alu_random");
  endtask

  task automatic test_load_wait;
    run_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 5'd9, 2'b10, 1'b0, 3, 32'hDEADBEEF, "load_wait");
    run_op(1'b0, 1'b1, 1'b1, 1'b0, 32'h204, 32'hCAFEF00D, 5'd4, 2'b10, 1'b0, 1, $urandom, "store_regwrite");
    run_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h300, 32'h0, 5'd11, 2'b10, 1'b0, int'(TMO), 32'h12345678, "ack_at_limit");
  endtask

  task automatic test_misalign;
    run_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h102, 32'h11223344, 5'd0, 2'b10, 1'b0, 0, 32'h0, "store_misalign");
    run_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h201, 32'h0, 5'd2, 2'b10, 1'b0, 0, 32'h0, "load_misalign");
  endtask

  task automatic test_timeout;
    run_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h400, 32'h0, 5'd6, 2'b10, 1'b0, 0, 32'h0, "timeout");
    run_op(1'b0, 1'b0, 1'b1, 1'b0, 32'h77, 32'h0, 5'd8, 2'b10, 1'b0, 0, 32'h0, "sticky_alu");
    run_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h404, 32'h0, 5'd6, 2'b10, 1'b0, 2, 32'hA5A5A5A5, "sticky_load");
  endtask

  task automatic test_reset_in_wait;
    ex_valid = 1'b1; memread = 1'b1; memwrite = 1'b0; regwrite = 1'b1; memtoreg = 1'b1;
    alurslt = 32'h200; wrreg = 5'd12;
`ifdef STAGE4_MEM_SUBWORD_EN
    mem_size = 2'b10; mem_sign = 1'b0;
`endif
    tick();
    ex_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    exp_bus_err = 1'b0;
    #1;
    checks++; if (dm_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rst_wait_handshake got=%0b/%0b exp=0/0", dm_req, stall); end
    checks++; if (wb_valid !== 1'b0 || bus_err !== 1'b0) begin errors++; $display("FAIL rst_wait_clear got=%0b/%0b exp=0/0", wb_valid, bus_err); end
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      dm_ack = 1'b1;
      dm_rdata = $urandom;
      #1;
      checks++; if (dm_req !== 1'b0) begin errors++; $display("FAIL rst_late_ack_req c%0d got=%0b exp=0", i, dm_req); end
      tick();
      checks++; if (wb_valid !== 1'b0 || regwrite_out !== 1'b0) begin errors++; $display("FAIL rst_late_ack_load c%0d got=%0b/%0b exp=0/0", i, wb_valid, regwrite_out); end
    end
    dm_ack = 1'b0;
  endtask

`ifdef STAGE4_MEM_SUBWORD_EN
  task automatic test_subword;
    run_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h103, 32'h0, 5'd7, 2'b00, 1'b1, 1, 32'h80000000, "byte_signed");
    run_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h102, 32'h0, 5'd7, 2'b01, 1'b0, 2, 32'h9ABC1234, "half_unsigned");
    run_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h101, 32'h000000EE, 5'd0, 2'b00, 1'b0, 1, $urandom, "byte_store");
    run_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h101, 32'h0, 5'd7, 2'b01, 1'b1, 1, $urandom, "half_misalign");
  endtask
`endif

  task automatic test_back_to_back;
    logic [31:0] a;
    logic [1:0]  sz;
    int kind;
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 3));
      a    = $urandom & 32'h0000FFFF;
`ifdef STAGE4_MEM_SUBWORD_EN
      sz = 2'($urandom_range(0, 2));
`else
      sz = 2'b10;
`endif
      if (kind == 3) begin
        sz = 2'b10;
        a  = a | 32'h1;
      end else begin
        a = a & ~(32'(m_lanes(sz)) - 32'h1);
      end
      case (kind)
        0: run_op(1'b0, 1'b0, 1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom),
                  sz, 1'($urandom), 0, 32'h0, "rand_alu");
        1: run_op(1'b1, 1'b0, 1'($urandom), 1'b1, a, $urandom, 5'($urandom),
                  sz, 1'($urandom), int'($urandom_range(0, TMO)), $urandom, "rand_load");
        2: run_op(1'b0, 1'b1, 1'($urandom), 1'b0, a, $urandom, 5'($urandom),
                  sz, 1'($urandom), int'($urandom_range(1, TMO)), $urandom, "rand_store");
        default: run_op(1'b1, 1'($urandom), 1'b1, 1'b1, a, $urandom, 5'($urandom),
                        sz, 1'b0, 1, $urandom, "rand_misalign");
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_misalign();
    test_timeout();
    test_reset_in_wait();
`ifdef STAGE4_MEM_SUBWORD_EN
    test_subword();
`endif
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
